writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Write-back stage and architectural register file of the pipelined MIPS core. It consumes the MEM/WB pipeline register outputs and formats load data by size and byte offset. It selects the write-back value and commits it to a 32×32 register file. The register file serves the ID stage's two read ports, a forwarding tap and a debug/display port, with write-first bypass.

## Interface
- No parameters; fixed 32 registers × 32 bits, register 0 hardwired to zero.
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- inRegWrite  in  1  write enable from MEM/WB
- inMemToRegMux  in  3  write-back source select
- inMemRead  in  2  load size/sign code
- inRegDest  in  5  destination register index
- inMemData  in  32  raw word read from data memory (little-endian)
- inALUResult  in  32  ALU result / effective address
- inData1  in  32  pass-through rs value
- inPCCounter  in  32  return address (already PC+4)
- inReadReg1, inReadReg2  in  5  ID-stage read indices
- inDebugReg  in  5  display read index
- outReadData1, outReadData2  out  32  ID-stage read data
- outDebugData  out  32  display read data
- outWriteData  out  32  formatted write-back value (to forwarding unit)
- outWriteReg  out  5  effective write index
- outWriteEnable  out  1  effective write enable

## Operation
- Load formatting, with lane = inALUResult[1:0]:
  - inMemRead 00 = word: inMemData unchanged.
  - inMemRead 01 = lh: half selected by inALUResult[1] (0 → [15:0], 1 → [31:16]), sign-extended. inALUResult[0] is ignored.
  - inMemRead 10 = lb: byte at lane, sign-extended.
  - inMemRead 11 = lbu: byte at lane, zero-extended.
- Write-back select, on inMemToRegMux:
  - 0 = inALUResult
  - 1 = formatted load data
  - 2 = inPCCounter
  - 3 = inData1
  - 4–7 reserved, treated as 0 (inALUResult).
- Effective write:
  - outWriteEnable = inRegWrite & (inRegDest != 0) & ~Rst.
  - outWriteReg = inRegDest.
  - outWriteData = selected value.
  - All three are combinational.
- Commit: at posedge Clk, if outWriteEnable, regs[inRegDest] <= outWriteData. Writes to register 0 are discarded.
- Reads (ports 1, 2 and debug):
  - Index 0 → 0.
  - Index equals inRegDest and outWriteEnable = 1 → outWriteData (write-first bypass).
  - Otherwise → regs[index].
- Reset: at posedge Clk with Rst = 1, all 32 registers are cleared to 0 and no write occurs, even if inRegWrite = 1.

## Timing
- Register array updates only on the rising Clk edge. Formatting, select, bypass and read paths are purely combinational, with zero cycle latency.
- A value written in cycle N is visible on the read ports:
  - during cycle N, through the bypass;
  - from cycle N+1 onward, from the array.
- While Rst = 1:
  - all read outputs and outDebugData are forced to 0;
  - outWriteEnable = 0.
- After Rst deasserts, every register reads 0 until written.
- Reset mid-operation: a write presented in the same cycle as Rst is lost. The pipeline must re-issue it.
- Simultaneous events:
  - Both read ports and the debug port may address the same register as the write in one cycle; all three see the bypassed value.
  - Only one write port exists, so no write–write conflict is possible.
- Unknown (X) inputs on unused paths must not reach the array when outWriteEnable = 0.

## Test plan
- Reset:
  - Write 0xDEADBEEF to r5.
  - Assert Rst for one cycle.
  - Read r5 → 0x00000000. outWriteEnable was 0 during reset.
- Load formatting:
  - inMemData = 0x80F17F22, inMemToRegMux = 1, inRegDest = 8.
  - lb (10) with lane 1: r8 = 0x0000007F.
  - lb with lane 3: 0xFFFFFF80.
  - lbu with lane 3: 0x00000080.
  - lh with inALUResult[1] = 1: 0xFFFF80F1.
  - lw: 0x80F17F22.
- Register zero:
  - inRegWrite = 1, inRegDest = 0, inALUResult = 0x12345678.
  - outWriteEnable = 0; reading r0 → 0; the array is unchanged.
- Write-first bypass:
  - In the same cycle, write r9 = 0x00000042 (mux 0) while inReadReg1 = inReadReg2 = inDebugReg = 9.
  - All three outputs show 0x00000042 in that cycle.
  - The next cycle, with inRegWrite = 0, still reads 0x00000042.
- Source select:
  - inPCCounter = 0x00400010, mux 2, dest r31 → r31 = 0x00400010.
  - inData1 = 0x0000ABCD, mux 3, dest r2 → r2 = 0x0000ABCD.
  - mux 5, inALUResult = 0x7 → r3 = 0x00000007.
- Reset collision: inRegWrite = 1, dest r4 = 0x11111111, with Rst = 1 in the same cycle → r4 reads 0 afterward.

Source files
------------

// File: rtl/writeback_regfile.sv
// Write-back stage and 32x32 architectural register file of the MIPS pipeline.
// Formats load data, selects the write-back value and serves three write-first read ports.
module writeback_regfile (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        inRegWrite,
  input  logic [2:0]  inMemToRegMux,
  input  logic [1:0]  inMemRead,
  input  logic [4:0]  inRegDest,
  input  logic [31:0] inMemData,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inData1,
  input  logic [31:0] inPCCounter,
  input  logic [4:0]  inReadReg1,
  input  logic [4:0]  inReadReg2,
  input  logic [4:0]  inDebugReg,
  output logic [31:0] outReadData1,
  output logic [31:0] outReadData2,
  output logic [31:0] outDebugData,
  output logic [31:0] outWriteData,
  output logic [4:0]  outWriteReg,
  output logic        outWriteEnable
);

  logic [31:0] regs [32];
  logic [31:0] load_data;

  function automatic logic [31:0] format_load(input logic [1:0]  code,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    // Halfword lane ignores address bit 0 (unaligned lh is not trapped here).
    h = lane[1] ? word[31:16] : word[15:0];
    case (code)
      2'b00:   format_load = word;
      2'b01:   format_load = {{16{h[15]}}, h};
      2'b10:   format_load = {{24{b[7]}}, b};
      default: format_load = {24'd0, b};
    endcase
  endfunction

  function automatic logic [31:0] read_port(input logic [4:0]  idx,
                                            input logic [31:0] stored);
    if (Rst || idx == 5'd0)
      read_port = 32'd0;
    else if (outWriteEnable && idx == inRegDest)
      read_port = outWriteData;
    else
      read_port = stored;
  endfunction

  always_comb begin
    load_data = format_load(inMemRead, inALUResult[1:0], inMemData);
    case (inMemToRegMux)
      3'd1:    outWriteData = load_data;
      3'd2:    outWriteData = inPCCounter;
      3'd3:    outWriteData = inData1;
      default: outWriteData = inALUResult;
    endcase
  end

  assign outWriteEnable = inRegWrite & (inRegDest != 5'd0) & ~Rst;
  assign outWriteReg    = inRegDest;

  assign outReadData1 = read_port(inReadReg1, regs[inReadReg1]);
  assign outReadData2 = read_port(inReadReg2, regs[inReadReg2]);
  assign outDebugData = read_port(inDebugReg, regs[inDebugReg]);

  // Commit stage: the gated enable keeps r0 and reset-cycle writes out of the array.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (outWriteEnable) begin
      regs[inRegDest] <= outWriteData;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: spec vectors, corner sequences
// and randomized traffic against an array-based reference model.
module tb_writeback_regfile;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        inRegWrite;
  logic [2:0]  inMemToRegMux;
  logic [1:0]  inMemRead;
  logic [4:0]  inRegDest;
  logic [31:0] inMemData, inALUResult, inData1, inPCCounter;
  logic [4:0]  inReadReg1, inReadReg2, inDebugReg;
  logic [31:0] outReadData1, outReadData2, outDebugData, outWriteData;
  logic [4:0]  outWriteReg;
  logic        outWriteEnable;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [32];

  always #5 Clk = ~Clk;

  writeback_regfile dut (
    .Clk(Clk), .Rst(Rst), .inRegWrite(inRegWrite), .inMemToRegMux(inMemToRegMux),
    .inMemRead(inMemRead), .inRegDest(inRegDest), .inMemData(inMemData),
    .inALUResult(inALUResult), .inData1(inData1), .inPCCounter(inPCCounter),
    .inReadReg1(inReadReg1), .inReadReg2(inReadReg2), .inDebugReg(inDebugReg),
    .outReadData1(outReadData1), .outReadData2(outReadData2), .outDebugData(outDebugData),
    .outWriteData(outWriteData), .outWriteReg(outWriteReg), .outWriteEnable(outWriteEnable)
  );

  typedef struct {
    logic        rw;
    logic [2:0]  mux;
    logic [1:0]  mr;
    logic [4:0]  dest;
    logic [31:0] mdata;
    logic [31:0] alu;
    logic [31:0] d1;
    logic [31:0] pc;
    logic [31:0] exp_wd;
    logic        exp_we;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sign/zero extension done by shifting the word down to the lane.
  function automatic logic [31:0] ref_load(input logic [1:0] code, input logic [31:0] addr,
                                           input logic [31:0] md);
    logic [31:0] sh;
    if (code == 2'b00) return md;
    if (code == 2'b01) begin
      sh = md >> (16 * addr[1]);
      return sh[15] ? (sh | 32'hFFFF0000) : (sh & 32'h0000FFFF);
    end
    sh = md >> (8 * addr[1:0]);
    if (code == 2'b10 && sh[7]) return sh | 32'hFFFFFF00;
    return sh & 32'h000000FF;
  endfunction

  function automatic logic [31:0] ref_wd();
    if (inMemToRegMux == 3'd1) return ref_load(inMemRead, inALUResult, inMemData);
    if (inMemToRegMux == 3'd2) return inPCCounter;
    if (inMemToRegMux == 3'd3) return inData1;
    return inALUResult;
  endfunction

  function automatic logic ref_we();
    return inRegWrite && inRegDest != 0 && !Rst;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (Rst || idx == 0) return 32'd0;
    if (ref_we() && idx == inRegDest) return ref_wd();
    return model[idx];
  endfunction

  // Checks all combinational outputs against the model, then clocks and updates the model.
  task automatic tick_check(input string tag);
    logic        we;
    logic [31:0] wd;
    #2;
    we = ref_we();
    wd = ref_wd();
    check({tag, ".we"},    {31'd0, outWriteEnable}, {31'd0, we});
    check({tag, ".wreg"},  {27'd0, outWriteReg},    {27'd0, inRegDest});
    check({tag, ".wdata"}, outWriteData, wd);
    check({tag, ".rd1"},   outReadData1, ref_read(inReadReg1));
    check({tag, ".rd2"},   outReadData2, ref_read(inReadReg2));
    check({tag, ".dbg"},   outDebugData, ref_read(inDebugReg));
    @(posedge Clk);
    if (Rst) for (int i = 0; i < 32; i++) model[i] = 32'd0;
    else if (we) model[inRegDest] = wd;
    #1;
  endtask

  task automatic drive(input logic rw, input logic [2:0] mux, input logic [1:0] mr,
                       input logic [4:0] dest, input logic [31:0] md, input logic [31:0] alu,
                       input logic [31:0] d1, input logic [31:0] pc);
    inRegWrite = rw; inMemToRegMux = mux; inMemRead = mr; inRegDest = dest;
    inMemData = md; inALUResult = alu; inData1 = d1; inPCCounter = pc;
  endtask

  task automatic add(input logic rw, input logic [2:0] mux, input logic [1:0] mr,
                     input logic [4:0] dest, input logic [31:0] md, input logic [31:0] alu,
                     input logic [31:0] d1, input logic [31:0] pc,
                     input logic [31:0] wd, input logic we);
    vec_t v;
    v.rw = rw; v.mux = mux; v.mr = mr; v.dest = dest; v.mdata = md; v.alu = alu;
    v.d1 = d1; v.pc = pc; v.exp_wd = wd; v.exp_we = we;
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    Rst = 1'b1;
    drive(1'b1, 3'd0, 2'b00, 5'd7, 32'h0, 32'hAAAA5555, 32'h0, 32'h0);
    inReadReg1 = 5'd7; inReadReg2 = 5'd0; inDebugReg = 5'd7;
    @(posedge Clk); #1;
    tick_check("reset_hold");
    check("reset.rd1_zero", outReadData1, 32'd0);
    check("reset.we_low", {31'd0, outWriteEnable}, 32'd0);

    // Write r5, reset for one cycle, expect r5 cleared.
    Rst = 1'b0;
    drive(1'b1, 3'd0, 2'b00, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    inDebugReg = 5'd5;
    tick_check("w_r5");
    inRegWrite = 1'b0;
    #1 check("r5.written", outDebugData, 32'hDEADBEEF);
    Rst = 1'b1;
    #1 check("r5.rst_we", {31'd0, outWriteEnable}, 32'd0);
    tick_check("r5_rst");
    Rst = 1'b0;
    #1 check("r5.cleared", outDebugData, 32'd0);

    // Spec vectors: load formatting, r0, source select.
    add(1, 3'd1, 2'b10, 5'd8, 32'h80F17F22, 32'h1, 0, 0, 32'h0000007F, 1);
    add(1, 3'd1, 2'b10, 5'd8, 32'h80F17F22, 32'h3, 0, 0, 32'hFFFFFF80, 1);
    add(1, 3'd1, 2'b11, 5'd8, 32'h80F17F22, 32'h3, 0, 0, 32'h00000080, 1);
    add(1, 3'd1, 2'b01, 5'd8, 32'h80F17F22, 32'h2, 0, 0, 32'hFFFF80F1, 1);
    add(1, 3'd1, 2'b01, 5'd8, 32'h80F17F22, 32'h3, 0, 0, 32'hFFFF80F1, 1);
    add(1, 3'd1, 2'b01, 5'd8, 32'h80F17F22, 32'h1, 0, 0, 32'h00007F22, 1);
    add(1, 3'd1, 2'b00, 5'd8, 32'h80F17F22, 32'h0, 0, 0, 32'h80F17F22, 1);
    add(1, 3'd1, 2'b11, 5'd8, 32'h80F17F22, 32'h0, 0, 0, 32'h00000022, 1);
    add(1, 3'd0, 2'b00, 5'd0, 32'h0, 32'h12345678, 0, 0, 32'h12345678, 0);
    add(1, 3'd2, 2'b00, 5'd31, 32'h0, 32'h1, 0, 32'h00400010, 32'h00400010, 1);
    add(1, 3'd3, 2'b00, 5'd2, 32'h0, 32'h1, 32'h0000ABCD, 0, 32'h0000ABCD, 1);
    add(1, 3'd5, 2'b01, 5'd3, 32'hFFFFFFFF, 32'h7, 32'h9, 32'h8, 32'h00000007, 1);
    add(0, 3'd0, 2'b00, 5'd2, 32'h0, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rw, tbl[i].mux, tbl[i].mr, tbl[i].dest, tbl[i].mdata,
            tbl[i].alu, tbl[i].d1, tbl[i].pc);
      inReadReg1 = 5'd0; inReadReg2 = 5'd1; inDebugReg = tbl[i].dest;
      #1;
      check($sformatf("vec%0d.wdata", i), outWriteData, tbl[i].exp_wd);
      check($sformatf("vec%0d.we", i), {31'd0, outWriteEnable}, {31'd0, tbl[i].exp_we});
      tick_check($sformatf("vec%0d", i));
      inRegWrite = 1'b0;
      #1;
      check($sformatf("vec%0d.readback", i), outDebugData,
            (tbl[i].exp_we) ? tbl[i].exp_wd : ((tbl[i].dest == 0) ? 32'd0 : model[tbl[i].dest]));
    end
    check("r2.kept", model[2], 32'h0000ABCD);

    // Write-first bypass on all three ports.
    drive(1'b1, 3'd0, 2'b00, 5'd9, 32'h0, 32'h00000042, 32'h0, 32'h0);
    inReadReg1 = 5'd9; inReadReg2 = 5'd9; inDebugReg = 5'd9;
    #1;
    check("bypass.rd1", outReadData1, 32'h42);
    check("bypass.rd2", outReadData2, 32'h42);
    check("bypass.dbg", outDebugData, 32'h42);
    tick_check("bypass");
    inRegWrite = 1'b0; inALUResult = 32'h0;
    #1;
    check("bypass.next_rd1", outReadData1, 32'h42);
    check("bypass.next_dbg", outDebugData, 32'h42);

    // Reset collision: write presented during reset is lost.
    drive(1'b1, 3'd0, 2'b00, 5'd4, 32'h0, 32'h55555555, 32'h0, 32'h0);
    inReadReg1 = 5'd4;
    tick_check("r4_pre");
    Rst = 1'b1; inALUResult = 32'h11111111;
    #1 check("collide.we", {31'd0, outWriteEnable}, 32'd0);
    tick_check("collide");
    Rst = 1'b0; inRegWrite = 1'b0;
    #1 check("collide.r4", outReadData1, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      Rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom);
      inReadReg1 = ($urandom_range(0, 3) == 0) ? inRegDest : 5'($urandom_range(0, 31));
      inReadReg2 = 5'($urandom_range(0, 31));
      inDebugReg = ($urandom_range(0, 3) == 0) ? inRegDest : 5'($urandom_range(0, 31));
      tick_check($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
